// File: rtl/vuart_uart_bridge_if.sv
// vuart_uart_bridge_if: APB link from the UART bridge to the vuart host port.
// master drives psel/penable/pwrite/paddr/pwdata; slave returns prdata/pready/pslverr.
interface vuart_uart_bridge_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [9:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/vuart_uart_bridge.sv
// vuart_uart_bridge: 8N1 UART <-> vuart host APB initiator (polls STAT, moves FIFO bytes).
// Ports: clk, rst_n, uart_tx/uart_rx, hostconn, APB master m, rx pulses; RX path needs VUART_BRIDGE_RX_EN.
module vuart_uart_bridge #(
  parameter int CLK_DIV = 16,
  parameter int W_DIV   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  uart_tx,
  input  logic                  uart_rx,
  output logic                  hostconn,
  vuart_uart_bridge_if.master   m,
  output logic                  rx_frame_err,
  output logic                  rx_overrun
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam logic [9:0] A_STAT = 10'h000;
  localparam logic [9:0] A_FIFO = 10'h004;

  localparam logic [W_DIV-1:0] DIV_LAST = W_DIV'(CLK_DIV - 1);

  logic [1:0]       st;
  logic             rxvld;
  logic             txrdy;
  logic [9:0]       tx_sh;
  logic [3:0]       tx_left;
  logic [W_DIV-1:0] tx_cnt;
  logic             tx_idle;
  logic             hold_vld;
  logic [7:0]       hold;
  logic             done;
  logic             is_fifo;
  logic             rd_done;
  logic             unused_bits;

  assign hostconn    = 1'b1;
  assign tx_idle     = (tx_left == 4'd0);
  assign done        = (st == ST_ACCESS) && m.pready;
  assign is_fifo     = (m.paddr == A_FIFO);
  assign rd_done     = done && is_fifo && !m.pwrite;
  assign unused_bits = &{1'b0, m.prdata[31:8]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_IDLE;
      m.psel    <= 1'b0;
      m.penable <= 1'b0;
      m.pwrite  <= 1'b0;
      m.paddr   <= '0;
      m.pwdata  <= '0;
      rxvld     <= 1'b0;
      txrdy     <= 1'b0;
    end else begin
      unique case (st)
        ST_IDLE: begin
          m.psel <= 1'b1;
          st     <= ST_SETUP;
          if (hold_vld && txrdy) begin
            m.pwrite <= 1'b1;
            m.paddr  <= A_FIFO;
            m.pwdata <= {24'd0, hold};
          end else if (tx_idle && rxvld) begin
            m.pwrite <= 1'b0;
            m.paddr  <= A_FIFO;
            m.pwdata <= '0;
          end else begin
            m.pwrite <= 1'b0;
            m.paddr  <= A_STAT;
            m.pwdata <= '0;
          end
        end
        ST_SETUP: begin
          m.penable <= 1'b1;
          st        <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (m.pready) begin
            m.psel    <= 1'b0;
            m.penable <= 1'b0;
            st        <= ST_IDLE;
            // any FIFO access invalidates the cached STAT view
            if (is_fifo) begin
              rxvld <= 1'b0;
              txrdy <= 1'b0;
            end else begin
              rxvld <= m.prdata[0] && !m.pslverr;
              txrdy <= m.prdata[1] && !m.pslverr;
            end
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  // tx_sh idles at all ones so uart_tx is high straight out of reset
  assign uart_tx = tx_sh[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sh   <= '1;
      tx_left <= 4'd0;
      tx_cnt  <= '0;
    end else if (rd_done && !m.pslverr) begin
      tx_sh   <= {1'b1, m.prdata[7:0], 1'b0};
      tx_left <= 4'd10;
      tx_cnt  <= '0;
    end else if (!tx_idle) begin
      if (tx_cnt == DIV_LAST) begin
        tx_cnt  <= '0;
        tx_sh   <= {1'b1, tx_sh[9:1]};
        tx_left <= tx_left - 4'd1;
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

`ifdef VUART_BRIDGE_RX_EN
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [W_DIV-1:0] HALF_LAST = W_DIV'(CLK_DIV / 2 - 1);

  logic             rx_q1;
  logic             rx_s;
  logic             rx_prev;
  logic [1:0]       rx_st;
  logic [W_DIV-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_sh;
  logic             wr_done;

  assign wr_done = done && is_fifo && m.pwrite;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_q1   <= uart_rx;
      rx_s    <= rx_q1;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st        <= RX_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= 3'd0;
      rx_sh        <= 8'd0;
      hold         <= 8'd0;
      hold_vld     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
      if (wr_done) hold_vld <= 1'b0;
      unique case (rx_st)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (rx_prev && !rx_s) rx_st <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            rx_bit <= 3'd0;
            rx_st  <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == DIV_LAST) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s, rx_sh[7:1]};
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_st <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == DIV_LAST) begin
            rx_cnt <= '0;
            rx_st  <= RX_IDLE;
            if (!rx_s) begin
              rx_frame_err <= 1'b1;
            end else if (hold_vld && !wr_done) begin
              rx_overrun <= 1'b1;
            end else begin
              // a slot freed by a write completing this cycle is reusable
              hold     <= rx_sh;
              hold_vld <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_st <= RX_IDLE;
      endcase
    end
  end
`else
  logic unused_rx;

  assign unused_rx    = &{1'b0, uart_rx};
  assign hold         = 8'd0;
  assign hold_vld     = 1'b0;
  assign rx_frame_err = 1'b0;
  assign rx_overrun   = 1'b0;
`endif

endmodule
